maj_vote_filter: RTL and testbench



---
 rtl/maj_vote_filter.sv | 192 +++++++++++++++++++
 tb/tb_maj_vote_filter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maj_vote_filter.sv
// maj_vote_filter: registered NUM_IN-way majority vote with a debounced output.
// Stage 1 captures the raw sample; stage 2 registers the vote, unanimity, the
// dissent count and the debounced vote_out/flip in the same edge.
// Optional feature macro: MAJ_VOTE_FILTER_ERRCNT_EN adds err_clr / err_cnt,
// a saturating count of non-unanimous results.
module maj_vote_filter #(
    parameter int unsigned NUM_IN   = 5,
    parameter int unsigned TIE_VAL  = 0,
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned CW       = $clog2(NUM_IN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [NUM_IN-1:0] in_bits,
    output logic              vote_valid,
    output logic              vote_raw,
    output logic              unanimous,
    output logic [CW-1:0]     dissent,
    output logic              vote_out,
    output logic              flip
`ifdef MAJ_VOTE_FILTER_ERRCNT_EN
    ,
    input  logic              err_clr,
    output logic [15:0]       err_cnt
`endif
);

    localparam int unsigned PW    = CW + 1;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // Stage 1 registers
    logic              r_s1_valid;
    logic [NUM_IN-1:0] r_s1_bits;

    // Stage 2 / result registers
    logic              r_vote_valid;
    logic              r_vote_raw;
    logic              r_unanimous;
    logic [CW-1:0]     r_dissent;
    logic              r_vote_out;
    logic              r_flip;
    logic [CNT_W-1:0]  r_cnt;
    state_t            r_state;

    // Combinational vote of the stage-1 sample
    logic [CW-1:0]     w_pc;
    logic [PW-1:0]     w_pc2;
    logic              w_vote;
    logic              w_unan;
    logic [CW-1:0]     w_dissent;

    // Debounce next-state
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_vote_out_nxt;
    logic              w_flip_nxt;

    // Stage 1: capture the raw sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_bits  <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_bits  <= in_bits;
        end
    end

    // Popcount and vote rule on the stage-1 sample
    always_comb begin
        w_pc = '0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            w_pc = w_pc + CW'(r_s1_bits[i]);
        end
        w_pc2 = {w_pc, 1'b0};
        if (w_pc2 > PW'(NUM_IN)) begin
            w_vote = 1'b1;
        end else if (w_pc2 < PW'(NUM_IN)) begin
            w_vote = 1'b0;
        end else begin
            w_vote = (TIE_VAL != 0);
        end
        w_dissent = w_vote ? (CW'(NUM_IN) - w_pc) : w_pc;
        w_unan    = (w_pc == '0) || (w_pc == CW'(NUM_IN));
    end

    // Stage 2: result registers, held when no sample arrives
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vote_valid <= 1'b0;
            r_vote_raw   <= 1'b0;
            r_unanimous  <= 1'b0;
            r_dissent    <= '0;
        end else begin
            r_vote_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_vote_raw  <= w_vote;
                r_unanimous <= w_unan;
                r_dissent   <= w_dissent;
            end
        end
    end

    // Debounce state register (shares the stage-2 edge)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_STABLE;
            r_cnt      <= '0;
            r_vote_out <= 1'b0;
            r_flip     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_vote_out <= w_vote_out_nxt;
            r_flip     <= w_flip_nxt;
        end
    end

    // Debounce next-state: only valid samples advance or clear the run
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_vote_out_nxt = r_vote_out;
        w_flip_nxt     = 1'b0;
        if (r_s1_valid) begin
            case (r_state)
                ST_STABLE: begin
                    if (w_vote != r_vote_out) begin
                        if (DEBOUNCE == 1) begin
                            w_vote_out_nxt = ~r_vote_out;
                            w_flip_nxt     = 1'b1;
                            w_cnt_nxt      = '0;
                        end else begin
                            w_cnt_nxt   = CNT_W'(1);
                            w_state_nxt = ST_PENDING;
                        end
                    end
                end
                ST_PENDING: begin
                    if (w_vote != r_vote_out) begin
                        if ((r_cnt + CNT_W'(1)) == CNT_W'(DEBOUNCE)) begin
                            w_vote_out_nxt = ~r_vote_out;
                            w_flip_nxt     = 1'b1;
                            w_cnt_nxt      = '0;
                            w_state_nxt    = ST_STABLE;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_STABLE;
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_STABLE;
                end
            endcase
        end
    end

`ifdef MAJ_VOTE_FILTER_ERRCNT_EN
    logic [15:0] r_err_cnt;

    // Saturating count of non-unanimous results; clear wins over increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (r_s1_valid && !w_unan && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign vote_valid = r_vote_valid;
    assign vote_raw   = r_vote_raw;
    assign unanimous  = r_unanimous;
    assign dissent    = r_dissent;
    assign vote_out   = r_vote_out;
    assign flip       = r_flip;

endmodule

// File: tb/tb_maj_vote_filter.sv
// Bench for maj_vote_filter: three instances (5-in/deb3, 4-in tie1/deb1,
// 4-in tie0/deb2) share one stimulus stream and are compared every cycle
// against a behavioural model built from vote counts and agreement runs.
module tb_maj_vote_filter;

    localparam int NI = 3;
    localparam int M_N   [NI] = '{5, 4, 4};
    localparam int M_TIE [NI] = '{0, 1, 0};
    localparam int M_DEB [NI] = '{3, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] in_bits;

    logic       o_vv   [NI];
    logic       o_raw  [NI];
    logic       o_un   [NI];
    logic [2:0] o_dis  [NI];
    logic       o_out  [NI];
    logic       o_flip [NI];

`ifdef MAJ_VOTE_FILTER_ERRCNT_EN
    logic        err_clr;
    logic [15:0] o_err;
    int          m_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model state per instance
    bit         m_p1v  [NI];
    logic [4:0] m_p1b  [NI];
    bit         m_vv   [NI];
    bit         m_raw  [NI];
    bit         m_un   [NI];
    int         m_dis  [NI];
    bit         m_out  [NI];
    bit         m_flip [NI];
    int         m_run  [NI];

    always #5 clk = ~clk;

    maj_vote_filter #(.NUM_IN(5), .TIE_VAL(0), .DEBOUNCE(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bits(in_bits),
        .vote_valid(o_vv[0]), .vote_raw(o_raw[0]), .unanimous(o_un[0]),
        .dissent(o_dis[0]), .vote_out(o_out[0]), .flip(o_flip[0])
`ifdef MAJ_VOTE_FILTER_ERRCNT_EN
        , .err_clr(err_clr), .err_cnt(o_err)
`endif
    );

    maj_vote_filter #(.NUM_IN(4), .TIE_VAL(1), .DEBOUNCE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bits(in_bits[3:0]),
        .vote_valid(o_vv[1]), .vote_raw(o_raw[1]), .unanimous(o_un[1]),
        .dissent(o_dis[1]), .vote_out(o_out[1]), .flip(o_flip[1])
`ifdef MAJ_VOTE_FILTER_ERRCNT_EN
        , .err_clr(err_clr), .err_cnt()
`endif
    );

    maj_vote_filter #(.NUM_IN(4), .TIE_VAL(0), .DEBOUNCE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bits(in_bits[3:0]),
        .vote_valid(o_vv[2]), .vote_raw(o_raw[2]), .unanimous(o_un[2]),
        .dissent(o_dis[2]), .vote_out(o_out[2]), .flip(o_flip[2])
`ifdef MAJ_VOTE_FILTER_ERRCNT_EN
        , .err_clr(err_clr), .err_cnt()
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Model of one edge for instance id, fed with the inputs sampled at that edge
    task automatic mdl_edge(input int id, input logic rn, input logic v, input logic [4:0] b);
        int pc;
        int n;
        n = M_N[id];
        if (!rn) begin
            m_p1v[id] = 0; m_p1b[id] = '0; m_vv[id] = 0; m_raw[id] = 0;
            m_un[id] = 0; m_dis[id] = 0; m_out[id] = 0; m_flip[id] = 0; m_run[id] = 0;
            return;
        end
        m_flip[id] = 0;
        m_vv[id]   = m_p1v[id];
        if (m_p1v[id]) begin
            pc = $countones(m_p1b[id] & 5'((1 << n) - 1));
            if (2 * pc > n)      m_raw[id] = 1;
            else if (2 * pc < n) m_raw[id] = 0;
            else                 m_raw[id] = (M_TIE[id] != 0);
            m_dis[id] = m_raw[id] ? (n - pc) : pc;
            m_un[id]  = (pc == 0) || (pc == n);
            if (m_raw[id] != m_out[id]) begin
                m_run[id]++;
                if (m_run[id] == M_DEB[id]) begin
                    m_out[id]  = ~m_out[id];
                    m_flip[id] = 1;
                    m_run[id]  = 0;
                end
            end else begin
                m_run[id] = 0;
            end
        end
        m_p1v[id] = v;
        m_p1b[id] = b;
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1ns later
    task automatic cyc(input logic rn, input logic v, input logic [4:0] b);
`ifdef MAJ_VOTE_FILTER_ERRCNT_EN
        bit cnt_it;
`endif
        rst_n    = rn;
        in_valid = v;
        in_bits  = b;
        @(posedge clk);
`ifdef MAJ_VOTE_FILTER_ERRCNT_EN
        cnt_it = m_p1v[0] && ($countones(m_p1b[0]) != 0) && ($countones(m_p1b[0]) != 5);
        if (!rn || err_clr) m_err = 0;
        else if (cnt_it && m_err != 65535) m_err++;
`endif
        for (int i = 0; i < NI; i++) mdl_edge(i, rn, v, b);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("vv%0d", i),   32'(o_vv[i]),   32'(m_vv[i]));
            chk($sformatf("raw%0d", i),  32'(o_raw[i]),  32'(m_raw[i]));
            chk($sformatf("un%0d", i),   32'(o_un[i]),   32'(m_un[i]));
            chk($sformatf("dis%0d", i),  32'(o_dis[i]),  32'(m_dis[i]));
            chk($sformatf("out%0d", i),  32'(o_out[i]),  32'(m_out[i]));
            chk($sformatf("flip%0d", i), 32'(o_flip[i]), 32'(m_flip[i]));
        end
`ifdef MAJ_VOTE_FILTER_ERRCNT_EN
        chk("err_cnt", 32'(o_err), 32'(m_err));
`endif
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        bit         tgt;
        logic [4:0] b;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bits  = '0;
`ifdef MAJ_VOTE_FILTER_ERRCNT_EN
        err_clr  = 1'b0;
        m_err    = 0;
`endif

        // Reset held with a live all-ones sample on the inputs
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 5'b11111);
        chk("rst_vv", 32'(o_vv[0]), 32'd0);
        chk("rst_out", 32'(o_out[0]), 32'd0);
        cyc(1'b1, 1'b1, 5'b11111);
        chk("post_rst_vv", 32'(o_vv[0]), 32'd0);
        cyc(1'b1, 1'b0, 5'd0);
        chk("first_vv", 32'(o_vv[0]), 32'd1);
        chk("first_raw", 32'(o_raw[0]), 32'd1);
        chk("first_un", 32'(o_un[0]), 32'd1);
        chk("first_dis", 32'(o_dis[0]), 32'd0);

        // Latency and vote rule
        do_reset(2);
        cyc(1'b1, 1'b1, 5'b00111);
        chk("lat_early", 32'(o_vv[0]), 32'd0);
        cyc(1'b1, 1'b0, 5'd0);
        chk("lat_vv", 32'(o_vv[0]), 32'd1);
        chk("v00111_raw", 32'(o_raw[0]), 32'd1);
        chk("v00111_dis", 32'(o_dis[0]), 32'd2);
        chk("v00111_un", 32'(o_un[0]), 32'd0);
        cyc(1'b1, 1'b1, 5'b00011);
        chk("hold_raw", 32'(o_raw[0]), 32'd1);
        cyc(1'b1, 1'b0, 5'd0);
        chk("v00011_raw", 32'(o_raw[0]), 32'd0);
        chk("v00011_dis", 32'(o_dis[0]), 32'd2);

        // Debounce: votes 1,1,0,1,1,1
        do_reset(2);
        cyc(1'b1, 1'b1, 5'b11100);
        cyc(1'b1, 1'b1, 5'b11100);
        cyc(1'b1, 1'b1, 5'b00001);
        cyc(1'b1, 1'b1, 5'b11100);
        cyc(1'b1, 1'b1, 5'b11100);
        cyc(1'b1, 1'b1, 5'b11100);
        chk("deb_before", 32'(o_out[0]), 32'd0);
        cyc(1'b1, 1'b0, 5'd0);
        chk("deb_flip", 32'(o_flip[0]), 32'd1);
        chk("deb_out", 32'(o_out[0]), 32'd1);
        cyc(1'b1, 1'b0, 5'd0);
        chk("deb_flip_once", 32'(o_flip[0]), 32'd0);

        // Gaps do not clear the run
        do_reset(2);
        cyc(1'b1, 1'b1, 5'b01110);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 5'd0);
        cyc(1'b1, 1'b1, 5'b10110);
        cyc(1'b1, 1'b1, 5'b11111);
        cyc(1'b1, 1'b0, 5'd0);
        chk("gap_flip", 32'(o_flip[0]), 32'd1);
        chk("gap_out", 32'(o_out[0]), 32'd1);

        // Ties on the 4-input instances (low nibble 0101)
        do_reset(2);
        cyc(1'b1, 1'b1, 5'b00101);
        cyc(1'b1, 1'b0, 5'd0);
        chk("tie1_raw", 32'(o_raw[1]), 32'd1);
        chk("tie1_dis", 32'(o_dis[1]), 32'd2);
        chk("tie0_raw", 32'(o_raw[2]), 32'd0);
        chk("tie0_dis", 32'(o_dis[2]), 32'd2);

        // Mid-run reset discards progress and in-flight samples
        do_reset(2);
        cyc(1'b1, 1'b1, 5'b11110);
        cyc(1'b1, 1'b1, 5'b11110);
        cyc(1'b0, 1'b1, 5'b11110);
        cyc(1'b1, 1'b1, 5'b11110);
        cyc(1'b1, 1'b0, 5'd0);
        cyc(1'b1, 1'b0, 5'd0);
        chk("mid_rst_out", 32'(o_out[0]), 32'd0);
        chk("mid_rst_flip", 32'(o_flip[0]), 32'd0);
`ifdef MAJ_VOTE_FILTER_ERRCNT_EN
        do_reset(1);
        chk("mid_rst_err", 32'(o_err), 32'd0);
`endif

        // Randomised runs with a slowly changing target vote
        tgt = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) tgt = ~tgt;
            for (int i = 0; i < 5; i++) b[i] = ($urandom_range(99) < 80) ? tgt : ~tgt;
`ifdef MAJ_VOTE_FILTER_ERRCNT_EN
            err_clr = ($urandom_range(99) == 0);
`endif
            cyc(($urandom_range(199) != 0), ($urandom_range(99) < 80), b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
